// File: rtl/spi_norflash_slave.sv
// ---------------------------------------------------------------------------
// spi_norflash_slave
// Byte-wide SPI NOR flash end-point. It decodes command frames from the
// APB-to-SPI NOR flash controller, holds a byte-addressed NOR array and
// returns read data on s_miso. Everything runs in the p_clk domain, and
// s_clk and s_css are oversampled.
//
// Ports:
//   p_clk        system clock
//   p_reset      asynchronous reset, active-high (also re-erases the array)
//   s_clk        SPI clock; data is taken on its rising edge
//   s_css        chip select, active-low, frames a transaction
//   s_mosi[7:0]  byte from the controller
//   s_miso[7:0]  byte to the controller
//   frame_active high from the css falling edge to the css rising edge
//   cmd_err      one-cycle pulse after an unknown command byte is captured
//
// Commands: 01 read, 02 program (AND into the array), C7 chip erase
// (1-byte frame only).
// Optional feature macro: SPI_WRITE_ENABLE_LATCH_EN adds command 06, which
// sets a write-enable latch. Program and erase then need the latch set.
// ---------------------------------------------------------------------------
module spi_norflash_slave #(
    parameter int ADDR_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       p_clk,
    input  logic       p_reset,
    input  logic       s_clk,
    input  logic       s_css,
    input  logic [7:0] s_mosi,
    output logic [7:0] s_miso,
    output logic       frame_active,
    output logic       cmd_err
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [7:0] CMD_READ  = 8'h01;
    localparam logic [7:0] CMD_PROG  = 8'h02;
    localparam logic [7:0] CMD_ERASE = 8'hC7;
`ifdef SPI_WRITE_ENABLE_LATCH_EN
    localparam logic [7:0] CMD_WREN  = 8'h06;
`endif

    // state     | meaning
    // ST_IDLE   | no frame in progress
    // ST_CMD    | waiting for the command byte
    // ST_ADDR   | collecting the three address bytes
    // ST_PROG   | data bytes are ANDed into the array
    // ST_READ   | array bytes are streamed out on s_miso
    // ST_IGNORE | rest of the frame is discarded
    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_PROG, ST_READ, ST_IGNORE
    } state_t;

    state_t r_state, w_state_nxt;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_css_sync;
    logic [7:0]             r_mosi_dly [SYNC_STAGES];
    logic                   r_sclk_prev;
    logic                   r_css_prev;

    logic [7:0]        r_byte_cnt;
    logic [7:0]        r_cmd;
    logic [15:0]       r_addr;
    logic [ADDR_W-1:0] r_ptr;
    logic [7:0]        r_miso;
    logic              r_frame;
    logic              r_cmd_err;
    logic [7:0]        r_mem [DEPTH];

    logic              w_sclk, w_css;
    logic [7:0]        w_mosi;
    logic              w_sclk_rise, w_css_fall, w_css_rise;
    logic              w_cmd_cap, w_addr_cap, w_addr_last, w_prog_rise, w_read_adv;
    logic              w_wel_ok, w_prog_wr, w_erase, w_cmd_bad;
    logic [23:0]       w_addr_full;
    logic [ADDR_W-1:0] w_addr_idx, w_ptr_inc;
    logic              w_unused_addr;

    function automatic logic f_cmd_known(input logic [7:0] c);
`ifdef SPI_WRITE_ENABLE_LATCH_EN
        return (c == CMD_READ) || (c == CMD_PROG) || (c == CMD_ERASE) || (c == CMD_WREN);
`else
        return (c == CMD_READ) || (c == CMD_PROG) || (c == CMD_ERASE);
`endif
    endfunction

    // s_mosi rides through the same number of stages as s_clk so that the
    // byte seen at a detected rising edge is the one sampled with it.
    always_ff @(posedge p_clk or posedge p_reset) begin
        if (p_reset) begin
            r_sclk_sync <= '0;
            r_css_sync  <= '1;
            r_sclk_prev <= 1'b0;
            r_css_prev  <= 1'b1;
            for (int i = 0; i < SYNC_STAGES; i++) r_mosi_dly[i] <= 8'h00;
        end else begin
            r_sclk_sync   <= {r_sclk_sync[SYNC_STAGES-2:0], s_clk};
            r_css_sync    <= {r_css_sync[SYNC_STAGES-2:0], s_css};
            r_mosi_dly[0] <= s_mosi;
            for (int i = 1; i < SYNC_STAGES; i++) r_mosi_dly[i] <= r_mosi_dly[i-1];
            r_sclk_prev   <= w_sclk;
            r_css_prev    <= w_css;
        end
    end

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_css       = r_css_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_dly[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_prev & ~w_css;
    assign w_css_fall  = ~w_css & r_css_prev;
    assign w_css_rise  = w_css & ~r_css_prev;

    assign w_addr_full   = {r_addr, w_mosi};
    assign w_addr_idx    = w_addr_full[ADDR_W-1:0];
    assign w_unused_addr = ^w_addr_full[23:ADDR_W];
    assign w_ptr_inc     = r_ptr + 1'b1;

    // FSM: state register
    always_ff @(posedge p_clk or posedge p_reset) begin
        if (p_reset) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        if (w_css_rise) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_css_fall) w_state_nxt = ST_CMD;
                ST_CMD:  if (w_sclk_rise) w_state_nxt = f_cmd_known(w_mosi) ? ST_ADDR : ST_IGNORE;
                ST_ADDR: begin
                    if (w_sclk_rise && (r_byte_cnt == 8'd3)) begin
                        case (r_cmd)
                            CMD_PROG: w_state_nxt = ST_PROG;
                            CMD_READ: w_state_nxt = ST_READ;
                            default:  w_state_nxt = ST_IGNORE;
                        endcase
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // FSM: per-state strobes
    always_comb begin
        w_cmd_cap   = 1'b0;
        w_addr_cap  = 1'b0;
        w_addr_last = 1'b0;
        w_prog_rise = 1'b0;
        w_read_adv  = 1'b0;
        case (r_state)
            ST_CMD:  w_cmd_cap = w_sclk_rise;
            ST_ADDR: begin
                w_addr_cap  = w_sclk_rise;
                w_addr_last = w_sclk_rise && (r_byte_cnt == 8'd3);
            end
            ST_PROG: w_prog_rise = w_sclk_rise;
            ST_READ: w_read_adv  = w_sclk_rise;
            default: ;
        endcase
    end

`ifdef SPI_WRITE_ENABLE_LATCH_EN
    logic r_wel;

    // The latch is consumed by any program or erase frame, whether or not
    // that frame actually changed the array.
    always_ff @(posedge p_clk or posedge p_reset) begin
        if (p_reset) begin
            r_wel <= 1'b0;
        end else if (w_css_rise && (r_byte_cnt != 8'd0)) begin
            if ((r_cmd == CMD_WREN) && (r_byte_cnt == 8'd1)) r_wel <= 1'b1;
            else if ((r_cmd == CMD_PROG) || (r_cmd == CMD_ERASE)) r_wel <= 1'b0;
        end
    end

    assign w_wel_ok = r_wel;
`else
    assign w_wel_ok = 1'b1;
`endif

    assign w_prog_wr = w_prog_rise && w_wel_ok;
    // A byte count of 1 at the end of the frame means only the command arrived.
    assign w_erase   = w_css_rise && (r_byte_cnt == 8'd1) && (r_cmd == CMD_ERASE) && w_wel_ok;
    assign w_cmd_bad = w_cmd_cap && !f_cmd_known(w_mosi);

    always_ff @(posedge p_clk or posedge p_reset) begin
        if (p_reset) begin
            r_byte_cnt <= 8'd0;
            r_cmd      <= 8'h00;
            r_addr     <= 16'h0000;
            r_ptr      <= '0;
            r_miso     <= 8'h00;
            r_frame    <= 1'b0;
            r_cmd_err  <= 1'b0;
        end else begin
            r_cmd_err <= w_cmd_bad;
            if (w_css_fall)      r_frame <= 1'b1;
            else if (w_css_rise) r_frame <= 1'b0;

            if (w_css_fall)                               r_byte_cnt <= 8'd0;
            else if (w_sclk_rise && (r_byte_cnt != 8'd255)) r_byte_cnt <= r_byte_cnt + 8'd1;

            if (w_cmd_cap)  r_cmd  <= w_mosi;
            if (w_addr_cap) r_addr <= w_addr_full[15:0];

            if (w_addr_last)                     r_ptr <= w_addr_idx;
            else if (w_prog_rise || w_read_adv)  r_ptr <= w_ptr_inc;

            if (w_addr_last && (r_cmd == CMD_READ)) r_miso <= r_mem[w_addr_idx];
            else if (w_read_adv)                    r_miso <= r_mem[w_ptr_inc];
        end
    end

    always_ff @(posedge p_clk or posedge p_reset) begin
        if (p_reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'hFF;
        end else if (w_erase) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'hFF;
        end else if (w_prog_wr) begin
            r_mem[r_ptr] <= r_mem[r_ptr] & w_mosi;
        end
    end

    assign s_miso       = r_miso;
    assign frame_active = r_frame;
    assign cmd_err      = r_cmd_err;

endmodule

// File: tb/tb_spi_norflash_slave.sv
module tb_spi_norflash_slave;

    logic       p_clk;
    logic       p_reset;
    logic       s_clk;
    logic       s_css;
    logic [7:0] s_mosi;
    logic [7:0] s_miso;
    logic       frame_active;
    logic       cmd_err;

    spi_norflash_slave #(.ADDR_W(8), .SYNC_STAGES(2)) dut (
        .p_clk        (p_clk),
        .p_reset      (p_reset),
        .s_clk        (s_clk),
        .s_css        (s_css),
        .s_mosi       (s_mosi),
        .s_miso       (s_miso),
        .frame_active (frame_active),
        .cmd_err      (cmd_err)
    );

    initial p_clk = 1'b0;
    always #5 p_clk = ~p_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int err_total = 0;

    always @(posedge p_clk) if (cmd_err === 1'b1) err_total++;

    localparam int OP_PROG  = 0;
    localparam int OP_READ  = 1;
    localparam int OP_ERASE = 2;
    localparam int OP_RAW   = 3;

    // d holds up to six bytes, first byte in the top bits.
    typedef struct {
        int          op;
        logic [7:0]  addr;
        int          n;
        logic [47:0] d;
        int          exp_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mkv(input int op, input logic [7:0] addr, input int n,
                                 input logic [47:0] d, input int exp_err);
        vec_t v;
        v.op = op; v.addr = addr; v.n = n; v.d = d; v.exp_err = exp_err;
        return v;
    endfunction

    function automatic logic [7:0] bk(input logic [47:0] d, input int k);
        return d[47-8*k -: 8];
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge p_clk);
    endtask

    task automatic spi_begin;
        s_css = 1'b0;
        clks(6);
    endtask

    task automatic spi_byte(input logic [7:0] b);
        s_mosi = b;
        clks(3);
        s_clk = 1'b1;
        clks(6);
        s_clk = 1'b0;
        clks(6);
    endtask

    task automatic spi_end;
        clks(4);
        s_css = 1'b1;
        clks(8);
    endtask

    task automatic send_wren;
`ifdef SPI_WRITE_ENABLE_LATCH_EN
        spi_begin; spi_byte(8'h06); spi_end;
`endif
    endtask

    task automatic do_prog(input logic [7:0] addr, input int n, input logic [47:0] d);
        send_wren;
        spi_begin;
        spi_byte(8'h02); spi_byte(8'h00); spi_byte(8'h00); spi_byte(addr);
        for (int k = 0; k < n; k++) spi_byte(bk(d, k));
        spi_end;
    endtask

    task automatic do_read(input string name, input logic [7:0] addr, input int n,
                           input logic [47:0] exp);
        spi_begin;
        check({name, " active"}, {7'd0, frame_active}, 8'd1);
        spi_byte(8'h01); spi_byte(8'h00); spi_byte(8'h00); spi_byte(addr);
        check($sformatf("%s rd0", name), s_miso, bk(exp, 0));
        for (int k = 1; k < n; k++) begin
            spi_byte(8'h00);
            check($sformatf("%s rd%0d", name, k), s_miso, bk(exp, k));
        end
        spi_end;
        check({name, " idle"}, {7'd0, frame_active}, 8'd0);
    endtask

    initial begin
        int err0;
        p_reset = 1'b1;
        s_clk   = 1'b0;
        s_css   = 1'b1;
        s_mosi  = 8'h00;

        tbl.push_back(mkv(OP_READ,  8'h10, 2, 48'hFF_FF_00_00_00_00, 0));
        tbl.push_back(mkv(OP_PROG,  8'h00, 4, 48'hFF_00_FF_00_00_00, 0));
        tbl.push_back(mkv(OP_READ,  8'h00, 4, 48'hFF_00_FF_00_00_00, 0));
        tbl.push_back(mkv(OP_PROG,  8'h05, 1, 48'hF0_00_00_00_00_00, 0));
        tbl.push_back(mkv(OP_PROG,  8'h05, 1, 48'h3C_00_00_00_00_00, 0));
        tbl.push_back(mkv(OP_READ,  8'h05, 1, 48'h30_00_00_00_00_00, 0));
        tbl.push_back(mkv(OP_PROG,  8'hFF, 2, 48'hAA_BB_00_00_00_00, 0));
        tbl.push_back(mkv(OP_READ,  8'hFF, 2, 48'hAA_BB_00_00_00_00, 0));
        tbl.push_back(mkv(OP_READ,  8'h00, 1, 48'hBB_00_00_00_00_00, 0));
        tbl.push_back(mkv(OP_RAW,   8'h00, 2, 48'hC7_00_00_00_00_00, 0));
        tbl.push_back(mkv(OP_READ,  8'h00, 1, 48'hBB_00_00_00_00_00, 0));
        tbl.push_back(mkv(OP_READ,  8'h05, 1, 48'h30_00_00_00_00_00, 0));
        tbl.push_back(mkv(OP_ERASE, 8'h00, 1, 48'hC7_00_00_00_00_00, 0));
        tbl.push_back(mkv(OP_READ,  8'h00, 1, 48'hFF_00_00_00_00_00, 0));
        tbl.push_back(mkv(OP_READ,  8'h05, 1, 48'hFF_00_00_00_00_00, 0));
        tbl.push_back(mkv(OP_READ,  8'hFF, 1, 48'hFF_00_00_00_00_00, 0));
        tbl.push_back(mkv(OP_PROG,  8'h05, 1, 48'h12_00_00_00_00_00, 0));
        tbl.push_back(mkv(OP_RAW,   8'h00, 5, 48'h55_00_00_05_00_00, 1));
        tbl.push_back(mkv(OP_READ,  8'h05, 1, 48'h12_00_00_00_00_00, 0));
        tbl.push_back(mkv(OP_RAW,   8'h00, 2, 48'h02_00_00_00_00_00, 0));
        tbl.push_back(mkv(OP_READ,  8'h05, 1, 48'h12_00_00_00_00_00, 0));

        clks(3);
        check("in_reset miso", s_miso, 8'h00);
        check("in_reset active", {7'd0, frame_active}, 8'd0);
        p_reset = 1'b0;
        clks(4);
        check("post_reset miso", s_miso, 8'h00);
        check("post_reset active", {7'd0, frame_active}, 8'd0);
        check("post_reset err", {7'd0, cmd_err}, 8'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            err0 = err_total;
            case (tbl[i].op)
                OP_PROG: do_prog(tbl[i].addr, tbl[i].n, tbl[i].d);
                OP_READ: do_read($sformatf("v%0d", i), tbl[i].addr, tbl[i].n, tbl[i].d);
                OP_ERASE: begin
                    send_wren;
                    spi_begin; spi_byte(8'hC7); spi_end;
                end
                default: begin
                    spi_begin;
                    for (int k = 0; k < tbl[i].n; k++) spi_byte(bk(tbl[i].d, k));
                    spi_end;
                end
            endcase
            check($sformatf("v%0d cmd_err cycles", i), 8'(err_total - err0), 8'(tbl[i].exp_err));
        end

        // Reset in the middle of a program frame: everything back to reset values.
        do_prog(8'h07, 1, 48'h00_00_00_00_00_00);
        spi_begin;
        spi_byte(8'h02); spi_byte(8'h00); spi_byte(8'h00); spi_byte(8'h09);
        s_mosi = 8'h00;
        clks(3);
        s_clk = 1'b1;
        clks(2);
        p_reset = 1'b1;
        clks(1);
        check("midreset miso", s_miso, 8'h00);
        check("midreset active", {7'd0, frame_active}, 8'd0);
        s_clk = 1'b0;
        s_css = 1'b1;
        clks(4);
        p_reset = 1'b0;
        clks(6);
        check("after_reset active", {7'd0, frame_active}, 8'd0);
        do_read("rst7", 8'h07, 1, 48'hFF_00_00_00_00_00);
        do_read("rst9", 8'h09, 1, 48'hFF_00_00_00_00_00);

`ifdef SPI_WRITE_ENABLE_LATCH_EN
        spi_begin;
        spi_byte(8'h02); spi_byte(8'h00); spi_byte(8'h00); spi_byte(8'h20); spi_byte(8'h00);
        spi_end;
        do_read("nowel", 8'h20, 1, 48'hFF_00_00_00_00_00);
        err0 = err_total;
        do_prog(8'h20, 1, 48'h00_00_00_00_00_00);
        check("wren no cmd_err", 8'(err_total - err0), 8'd0);
        do_read("wel", 8'h20, 1, 48'h00_00_00_00_00_00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
